// File: rtl/bin2ascii_seq.sv
// bin2ascii_seq: sequential binary-to-ASCII decimal converter (double dabble).
// Converts one bit per clock, then formats the BCD result as ASCII with
// optional leading-zero blanking and saturation to all '9' on overflow.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      conversion request, honoured only while idle
//   bin        unsigned value, captured when start is accepted
//   busy       high while a conversion is in progress
//   done       one-cycle pulse when ascii_out/overflow are updated
//   ascii_out  DIGITS ASCII characters, byte [7:0] = least significant digit
//   overflow   last converted value did not fit in DIGITS decimal digits
module bin2ascii_seq #(
  parameter int BIN_W    = 16,
  parameter int DIGITS   = 5,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [8*DIGITS-1:0]   ascii_out,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

  state_t              state;
  logic [BIN_W-1:0]    shift_q;
  logic [BCD_W-1:0]    bcd_q;
  logic                sticky_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [BCD_W-1:0]    bcd_adj;
  logic [8*DIGITS-1:0] ascii_fmt;
  logic [8*DIGITS-1:0] ascii_rst;

  // add-3 correction applied to every nibble before the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Output formatting. Scanning from the MSD down, 'seen' goes high at the
  // first nonzero digit (or at the LSD) so only true leading zeros blank.
  always_comb begin
    logic        seen;
    logic [3:0]  digit;
    int unsigned idx;
    ascii_fmt = '0;
    ascii_rst = '0;
    seen      = 1'b0;
    digit     = '0;
    idx       = 0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      idx   = DIGITS - 1 - k;
      digit = bcd_q[4*idx +: 4];
      ascii_rst[8*idx +: 8] = (idx == 0 || !BLANK_LZ) ? 8'h30 : 8'h20;
      if (sticky_q) begin
        ascii_fmt[8*idx +: 8] = 8'h39;
      end else begin
        if (digit != 4'd0 || idx == 0)
          seen = 1'b1;
        if (seen)
          ascii_fmt[8*idx +: 8] = {4'h3, digit};
        else
          ascii_fmt[8*idx +: 8] = BLANK_LZ ? 8'h20 : 8'h30;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      sticky_q  <= 1'b0;
      shift_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ascii_out <= ascii_rst;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_q  <= bin;
            bcd_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= CNT_W'(BIN_W);
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // the bit leaving the top nibble means the value exceeds DIGITS digits
          {bcd_q, shift_q} <= {bcd_adj[BCD_W-2:0], shift_q, 1'b0};
          sticky_q         <= sticky_q | bcd_adj[BCD_W-1];
          cnt_q            <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1))
            state <= FORMAT;
        end
        FORMAT: begin
          ascii_out <= ascii_fmt;
          overflow  <= sticky_q;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2ascii_seq.sv
module tb_bin2ascii_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s0, s1, s2, s3;
  logic [15:0] b0, b1;
  logic [7:0]  b2;
  logic [9:0]  b3;
  logic        bz0, bz1, bz2, bz3;
  logic        dn0, dn1, dn2, dn3;
  logic        ov0, ov1, ov2, ov3;
  logic [39:0] a0, a1;
  logic [15:0] a2;
  logic [23:0] a3;

  bin2ascii_seq #(.BIN_W(16), .DIGITS(5), .BLANK_LZ(1'b1)) u0 (
    .clk(clk), .rst(rst), .start(s0), .bin(b0), .busy(bz0), .done(dn0),
    .ascii_out(a0), .overflow(ov0));
  bin2ascii_seq #(.BIN_W(16), .DIGITS(5), .BLANK_LZ(1'b0)) u1 (
    .clk(clk), .rst(rst), .start(s1), .bin(b1), .busy(bz1), .done(dn1),
    .ascii_out(a1), .overflow(ov1));
  bin2ascii_seq #(.BIN_W(8), .DIGITS(2), .BLANK_LZ(1'b1)) u2 (
    .clk(clk), .rst(rst), .start(s2), .bin(b2), .busy(bz2), .done(dn2),
    .ascii_out(a2), .overflow(ov2));
  bin2ascii_seq #(.BIN_W(10), .DIGITS(3), .BLANK_LZ(1'b1)) u3 (
    .clk(clk), .rst(rst), .start(s3), .bin(b3), .busy(bz3), .done(dn3),
    .ascii_out(a3), .overflow(ov3));

  int bw[4] = '{16, 16, 8, 10};
  int dg[4] = '{5, 5, 2, 3};
  bit bl[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  typedef struct {
    int          k;
    logic [63:0] a;
    logic        o;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  function automatic logic [63:0] asc_of(input int k);
    case (k)
      0: return {24'h0, a0};
      1: return {24'h0, a1};
      2: return {48'h0, a2};
      default: return {40'h0, a3};
    endcase
  endfunction

  function automatic logic busy_of(input int k);
    case (k)
      0: return bz0;
      1: return bz1;
      2: return bz2;
      default: return bz3;
    endcase
  endfunction

  function automatic logic done_of(input int k);
    case (k)
      0: return dn0;
      1: return dn1;
      2: return dn2;
      default: return dn3;
    endcase
  endfunction

  function automatic logic ovf_of(input int k);
    case (k)
      0: return ov0;
      1: return ov1;
      2: return ov2;
      default: return ov3;
    endcase
  endfunction

  // Reference: decimal digits by division, then saturation or blanking.
  function automatic void model(input int unsigned v, input int d, input bit blank,
                                output logic [63:0] a, output logic o);
    int unsigned lim = 1;
    int unsigned x;
    int unsigned dig[8];
    bit seen = 1'b0;
    a = '0;
    for (int i = 0; i < d; i++) lim = lim * 10;
    o = (v >= lim);
    x = v;
    for (int i = 0; i < d; i++) begin
      dig[i] = x % 10;
      x = x / 10;
    end
    for (int i = d - 1; i >= 0; i--) begin
      if (o) begin
        a[8*i +: 8] = 8'h39;
      end else begin
        if (dig[i] != 0 || i == 0) seen = 1'b1;
        if (seen) a[8*i +: 8] = 8'(32'h30 + dig[i]);
        else      a[8*i +: 8] = blank ? 8'h20 : 8'h30;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_st(input int k, input logic s);
    case (k)
      0: s0 = s;
      1: s1 = s;
      2: s2 = s;
      default: s3 = s;
    endcase
  endtask

  task automatic set_in(input int k, input logic s, input int unsigned v);
    set_st(k, s);
    case (k)
      0: b0 = v[15:0];
      1: b1 = v[15:0];
      2: b2 = v[7:0];
      default: b3 = v[9:0];
    endcase
  endtask

  // Drive start for one edge (accept edge); optionally record the expectation.
  task automatic launch(input int k, input int unsigned v, input bit push);
    exp_t e;
    set_in(k, 1'b1, v);
    if (push) begin
      e.k = k;
      model(v, dg[k], bl[k], e.a, e.o);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    set_st(k, 1'b0);
    chk("busy_after_start", {63'h0, busy_of(k)}, 64'd1);
    chk("done_low_after_start", {63'h0, done_of(k)}, 64'd0);
  endtask

  // Wait (bounded) for done; p1/p2 are cycles at which a stray start with
  // bin=999 is driven while the conversion is running.
  task automatic wait_done(input int k, input int p1, input int p2);
    int   c;
    bit   got = 1'b0;
    exp_t e;
    for (c = 1; c <= 40; c++) begin
      if (c == p1 || c == p2) set_in(k, 1'b1, 999);
      @(posedge clk);
      #1;
      set_st(k, 1'b0);
      if (done_of(k)) begin
        got = 1'b1;
        break;
      end
    end
    chk("latency", got ? 64'(c) : 64'd0, 64'(bw[k] + 1));
    chk("busy_at_done", {63'h0, busy_of(k)}, 64'd0);
    chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("sb_inst", 64'(e.k), 64'(k));
      chk("ascii", asc_of(k), e.a);
      chk("overflow", {63'h0, ovf_of(k)}, {63'h0, e.o});
    end
  endtask

  task automatic convert(input int k, input int unsigned v);
    launch(k, v, 1'b1);
    wait_done(k, 0, 0);
  endtask

  initial begin
    bit seen_done;
    rst = 1'b1;
    s0 = 0; s1 = 0; s2 = 0; s3 = 0;
    b0 = '0; b1 = '0; b2 = '0; b3 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_busy", {60'h0, bz0, bz1, bz2, bz3}, 64'd0);
    chk("rst_done", {60'h0, dn0, dn1, dn2, dn3}, 64'd0);
    chk("rst_ovf",  {60'h0, ov0, ov1, ov2, ov3}, 64'd0);
    chk("rst_ascii0", {24'h0, a0}, 64'h2020202030);
    chk("rst_ascii1", {24'h0, a1}, 64'h3030303030);
    chk("rst_ascii2", {48'h0, a2}, 64'h2030);
    chk("rst_ascii3", {40'h0, a3}, 64'h202030);

    convert(0, 0);
    chk("zero_text", {24'h0, a0}, 64'h2020202030);
    convert(0, 65535);
    chk("max_text", {24'h0, a0}, 64'h3635353335);
    convert(0, 1205);
    chk("blank_text", {24'h0, a0}, 64'h2031323035);
    convert(1, 1205);
    chk("noblank_text", {24'h0, a1}, 64'h3031323035);
    convert(1, 0);
    convert(1, 65535);

    convert(2, 99);
    chk("w8_99", {47'h0, ov2, a2}, 64'h3939);
    convert(2, 100);
    chk("w8_100", {47'h0, ov2, a2}, 64'h13939);
    convert(2, 255);
    convert(2, 7);
    chk("w8_7", {47'h0, ov2, a2}, 64'h2037);
    convert(3, 999);
    convert(3, 1000);
    convert(3, 1023);
    convert(3, 0);

    // stray starts while busy are ignored; start in the done cycle is taken
    launch(0, 42, 1'b1);
    wait_done(0, 3, 10);
    chk("ignore_text", {24'h0, a0}, 64'h2020203432);
    launch(0, 999, 1'b1);
    wait_done(0, 0, 0);
    chk("b2b_text", {24'h0, a0}, 64'h2020393939);

    // reset mid-conversion aborts with no done pulse
    launch(0, 12345, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", {63'h0, bz0}, 64'd0);
    chk("abort_done", {63'h0, dn0}, 64'd0);
    chk("abort_ovf",  {63'h0, ov0}, 64'd0);
    chk("abort_ascii", {24'h0, a0}, 64'h2020202030);
    seen_done = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (dn0 || bz0) seen_done = 1'b1;
    end
    chk("abort_quiet", {63'h0, seen_done}, 64'd0);
    convert(0, 300);
    chk("after_abort_text", {24'h0, a0}, 64'h2020333030);

    for (int i = 0; i < 500; i++) convert(0, $urandom_range(65535));
    for (int i = 0; i < 500; i++) convert(3, $urandom_range(1023));

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
